// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: decoded ID operands, EX/MEM and MEM/WB forwarding taps, and the EX-side
// operand/control outputs feeding the ALU and memory stages.
interface id_ex_stage_if #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned REG_ADDR_W = 3
);
    logic                  stall;
    logic                  flush;

    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs_addr;
    logic [REG_ADDR_W-1:0] id_rt_addr;
    logic [REG_ADDR_W-1:0] id_rd_addr;
    logic [DATA_W-1:0]     id_rs_data;
    logic [DATA_W-1:0]     id_rt_data;
    logic [DATA_W-1:0]     id_imm;
    logic [3:0]            id_alu_op;
    logic                  id_alu_src;
    logic                  id_reg_write;
    logic                  id_mem_read;
    logic                  id_mem_write;

    logic                  exmem_reg_write;
    logic [REG_ADDR_W-1:0] exmem_rd;
    logic [DATA_W-1:0]     exmem_result;
    logic                  memwb_reg_write;
    logic [REG_ADDR_W-1:0] memwb_rd;
    logic [DATA_W-1:0]     memwb_result;

    logic [DATA_W-1:0]     alu_a;
    logic [DATA_W-1:0]     alu_b;
    logic [3:0]            alu_op;
    logic                  ex_valid;
    logic                  ex_reg_write;
    logic                  ex_mem_read;
    logic                  ex_mem_write;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic [DATA_W-1:0]     ex_store_data;
    logic                  hazard_stall;

    modport master (
        output stall, flush,
        output id_valid, id_rs_addr, id_rt_addr, id_rd_addr, id_rs_data, id_rt_data, id_imm,
        output id_alu_op, id_alu_src, id_reg_write, id_mem_read, id_mem_write,
        output exmem_reg_write, exmem_rd, exmem_result,
        output memwb_reg_write, memwb_rd, memwb_result,
        input  alu_a, alu_b, alu_op, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write,
        input  ex_rd, ex_store_data, hazard_stall
    );

    modport slave (
        input  stall, flush,
        input  id_valid, id_rs_addr, id_rt_addr, id_rd_addr, id_rs_data, id_rt_data, id_imm,
        input  id_alu_op, id_alu_src, id_reg_write, id_mem_read, id_mem_write,
        input  exmem_reg_write, exmem_rd, exmem_result,
        input  memwb_reg_write, memwb_rd, memwb_result,
        output alu_a, alu_b, alu_op, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write,
        output ex_rd, ex_store_data, hazard_stall
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX operand forwarding from EX/MEM and MEM/WB and
// load-use hazard detection.
module id_ex_stage #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned REG_ADDR_W = 3
) (
    input  logic         clk,
    input  logic         rst,
    id_ex_stage_if.slave bus
);
    logic                  valid_q;
    logic                  reg_write_q;
    logic                  mem_read_q;
    logic                  mem_write_q;
    logic                  alu_src_q;
    logic [REG_ADDR_W-1:0] rs_q;
    logic [REG_ADDR_W-1:0] rt_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic [DATA_W-1:0]     rs_data_q;
    logic [DATA_W-1:0]     rt_data_q;
    logic [DATA_W-1:0]     imm_q;
    logic [3:0]            alu_op_q;

    logic                  hazard;
    logic                  bubble;
    logic [DATA_W-1:0]     fwd_rs;
    logic [DATA_W-1:0]     fwd_rt;

    // rt is compared even for immediate-form instructions: a spurious stall is harmless.
    assign hazard = valid_q & mem_read_q & (rd_q != '0) & bus.id_valid &
                    ((rd_q == bus.id_rs_addr) | (rd_q == bus.id_rt_addr));

    // An external stall holds the load in EX, so a load-use bubble only goes in when free.
    assign bubble = bus.flush | (hazard & ~bus.stall);

    always_ff @(posedge clk) begin
        if (rst || bubble) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            alu_src_q   <= 1'b0;
            rs_q        <= '0;
            rt_q        <= '0;
            rd_q        <= '0;
            rs_data_q   <= '0;
            rt_data_q   <= '0;
            imm_q       <= '0;
            alu_op_q    <= '0;
        end else if (!bus.stall) begin
            valid_q     <= bus.id_valid;
            reg_write_q <= bus.id_reg_write;
            mem_read_q  <= bus.id_mem_read;
            mem_write_q <= bus.id_mem_write;
            alu_src_q   <= bus.id_alu_src;
            rs_q        <= bus.id_rs_addr;
            rt_q        <= bus.id_rt_addr;
            rd_q        <= bus.id_rd_addr;
            rs_data_q   <= bus.id_rs_data;
            rt_data_q   <= bus.id_rt_data;
            imm_q       <= bus.id_imm;
            alu_op_q    <= bus.id_alu_op;
        end
    end

    // EX/MEM is the younger producer, so it is checked first.
    always_comb begin
        fwd_rs = rs_data_q;
        if (bus.exmem_reg_write && (bus.exmem_rd == rs_q) && (rs_q != '0)) begin
            fwd_rs = bus.exmem_result;
        end else if (bus.memwb_reg_write && (bus.memwb_rd == rs_q) && (rs_q != '0)) begin
            fwd_rs = bus.memwb_result;
        end
    end

    always_comb begin
        fwd_rt = rt_data_q;
        if (bus.exmem_reg_write && (bus.exmem_rd == rt_q) && (rt_q != '0)) begin
            fwd_rt = bus.exmem_result;
        end else if (bus.memwb_reg_write && (bus.memwb_rd == rt_q) && (rt_q != '0)) begin
            fwd_rt = bus.memwb_result;
        end
    end

    assign bus.alu_a         = fwd_rs;
    assign bus.alu_b         = alu_src_q ? imm_q : fwd_rt;
    assign bus.alu_op        = alu_op_q;
    assign bus.ex_valid      = valid_q;
    assign bus.ex_reg_write  = reg_write_q;
    assign bus.ex_mem_read   = mem_read_q;
    assign bus.ex_mem_write  = mem_write_q;
    assign bus.ex_rd         = rd_q;
    assign bus.ex_store_data = fwd_rt;
    assign bus.hazard_stall  = hazard;
endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed scenarios followed by random traffic, checked
// against a behavioural pipeline model.
module tb_id_ex_stage;
    logic clk;
    logic rst;

    id_ex_stage_if bus ();

    id_ex_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst;
        logic        stall;
        logic        flush;
        logic        id_valid;
        logic [2:0]  rs;
        logic [2:0]  rt;
        logic [2:0]  rd;
        logic [15:0] rs_data;
        logic [15:0] rt_data;
        logic [15:0] imm;
        logic [3:0]  op;
        logic        alu_src;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        exmem_we;
        logic [2:0]  exmem_rd;
        logic [15:0] exmem_val;
        logic        memwb_we;
        logic [2:0]  memwb_rd;
        logic [15:0] memwb_val;
    } stim_t;

    // The instruction sitting in EX, as the model sees it.
    typedef struct packed {
        logic        valid;
        logic [2:0]  rs;
        logic [2:0]  rt;
        logic [2:0]  rd;
        logic [15:0] rs_data;
        logic [15:0] rt_data;
        logic [15:0] imm;
        logic [3:0]  op;
        logic        alu_src;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
    } instr_t;

    typedef struct packed {
        logic        chk;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  op;
        logic        valid;
        logic        rw;
        logic        mr;
        logic        mw;
        logic [2:0]  rd;
        logic [15:0] sd;
        logic        hz;
    } out_t;

    out_t   exp_q[$];
    instr_t ex;
    int     n_cmp = 0;
    int     n_bad = 0;
    int     cyc   = 0;
    bit     first = 1'b1;

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    // Producers listed youngest first; the first one writing src supplies the value.
    function automatic logic [15:0] operand(input logic [2:0] src, input logic [15:0] regval,
                                            input stim_t s);
        logic        we [2];
        logic [2:0]  dst [2];
        logic [15:0] val [2];
        we[0] = s.exmem_we; dst[0] = s.exmem_rd; val[0] = s.exmem_val;
        we[1] = s.memwb_we; dst[1] = s.memwb_rd; val[1] = s.memwb_val;
        if (src == 3'd0) return regval;
        for (int i = 0; i < 2; i++) begin
            if (we[i] && dst[i] == src) return val[i];
        end
        return regval;
    endfunction

    function automatic logic load_use(input instr_t e, input stim_t s);
        return e.valid && e.mem_read && e.rd != 3'd0 && s.id_valid &&
               (e.rd == s.rs || e.rd == s.rt);
    endfunction

    function automatic out_t predict(input instr_t e, input stim_t s);
        out_t o;
        o.chk   = 1'b1;
        o.a     = operand(e.rs, e.rs_data, s);
        o.sd    = operand(e.rt, e.rt_data, s);
        o.b     = e.alu_src ? e.imm : o.sd;
        o.op    = e.op;
        o.valid = e.valid;
        o.rw    = e.reg_write;
        o.mr    = e.mem_read;
        o.mw    = e.mem_write;
        o.rd    = e.rd;
        o.hz    = load_use(e, s);
        return o;
    endfunction

    function automatic instr_t advance(input instr_t e, input stim_t s);
        instr_t n;
        if (s.rst || s.flush || (load_use(e, s) && !s.stall)) return '0;
        if (s.stall) return e;
        n.valid     = s.id_valid;
        n.rs        = s.rs;
        n.rt        = s.rt;
        n.rd        = s.rd;
        n.rs_data   = s.rs_data;
        n.rt_data   = s.rt_data;
        n.imm       = s.imm;
        n.op        = s.op;
        n.alu_src   = s.alu_src;
        n.reg_write = s.reg_write;
        n.mem_read  = s.mem_read;
        n.mem_write = s.mem_write;
        return n;
    endfunction

    task automatic step(input stim_t s);
        out_t o;
        @(negedge clk);
        rst                 = s.rst;
        bus.stall           = s.stall;
        bus.flush           = s.flush;
        bus.id_valid        = s.id_valid;
        bus.id_rs_addr      = s.rs;
        bus.id_rt_addr      = s.rt;
        bus.id_rd_addr      = s.rd;
        bus.id_rs_data      = s.rs_data;
        bus.id_rt_data      = s.rt_data;
        bus.id_imm          = s.imm;
        bus.id_alu_op       = s.op;
        bus.id_alu_src      = s.alu_src;
        bus.id_reg_write    = s.reg_write;
        bus.id_mem_read     = s.mem_read;
        bus.id_mem_write    = s.mem_write;
        bus.exmem_reg_write = s.exmem_we;
        bus.exmem_rd        = s.exmem_rd;
        bus.exmem_result    = s.exmem_val;
        bus.memwb_reg_write = s.memwb_we;
        bus.memwb_rd        = s.memwb_rd;
        bus.memwb_result    = s.memwb_val;
        o = predict(ex, s);
        // Before the first reset edge the DUT state is unknown.
        if (first) o.chk = 1'b0;
        first = 1'b0;
        exp_q.push_back(o);
        ex = advance(ex, s);
    endtask

    function automatic stim_t rand_stim();
        stim_t s;
        s.rst       = ($urandom_range(63) == 0);
        s.stall     = ($urandom_range(4) == 0);
        s.flush     = ($urandom_range(7) == 0);
        s.id_valid  = ($urandom_range(5) != 0);
        s.rs        = 3'($urandom_range(7));
        s.rt        = 3'($urandom_range(7));
        s.rd        = 3'($urandom_range(7));
        s.rs_data   = (s.rs == 3'd0) ? 16'h0 : 16'($urandom);
        s.rt_data   = (s.rt == 3'd0) ? 16'h0 : 16'($urandom);
        s.imm       = 16'($urandom);
        s.op        = 4'($urandom_range(15));
        s.alu_src   = 1'($urandom_range(1));
        s.reg_write = 1'($urandom_range(1));
        s.mem_read  = ($urandom_range(2) == 0);
        s.mem_write = ($urandom_range(3) == 0);
        s.exmem_we  = 1'($urandom_range(1));
        s.exmem_rd  = 3'($urandom_range(7));
        s.exmem_val = 16'($urandom);
        s.memwb_we  = 1'($urandom_range(1));
        s.memwb_rd  = 3'($urandom_range(7));
        s.memwb_val = 16'($urandom);
        return s;
    endfunction

    // Monitor: every cycle the stage presents a full set of EX outputs.
    initial begin
        out_t e;
        out_t g;
        forever begin
            @(negedge clk);
            #3;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                cyc++;
                if (e.chk) begin
                    g.chk   = 1'b1;
                    g.a     = bus.alu_a;
                    g.b     = bus.alu_b;
                    g.op    = bus.alu_op;
                    g.valid = bus.ex_valid;
                    g.rw    = bus.ex_reg_write;
                    g.mr    = bus.ex_mem_read;
                    g.mw    = bus.ex_mem_write;
                    g.rd    = bus.ex_rd;
                    g.sd    = bus.ex_store_data;
                    g.hz    = bus.hazard_stall;
                    n_cmp++;
                    if (g !== e) begin
                        n_bad++;
                        $display({"FAIL ex_outputs cycle %0d: got a=%h b=%h op=%h v=%b rw=%b ",
                                  "mr=%b mw=%b rd=%0d sd=%h hz=%b, want a=%h b=%h op=%h v=%b ",
                                  "rw=%b mr=%b mw=%b rd=%0d sd=%h hz=%b"},
                                 cyc, g.a, g.b, g.op, g.valid, g.rw, g.mr, g.mw, g.rd, g.sd,
                                 g.hz, e.a, e.b, e.op, e.valid, e.rw, e.mr, e.mw, e.rd, e.sd,
                                 e.hz);
                    end
                end
            end
        end
    end

    initial begin
        stim_t s;
        ex = '0;

        // Power-up reset, then reset state is observed.
        s = idle(); s.rst = 1'b1;
        step(s);
        step(s);

        // Plain pass-through of regfile operands.
        s = idle(); s.id_valid = 1'b1; s.rs = 3'd1; s.rs_data = 16'h0005;
        s.rt = 3'd2; s.rt_data = 16'h0003; s.rd = 3'd5; s.reg_write = 1'b1;
        step(s);
        step(idle());

        // Forwarding priority on rs=2, then r0 never forwarded.
        s = idle(); s.id_valid = 1'b1; s.rs = 3'd2; s.rs_data = 16'h0ABC; s.rd = 3'd6;
        step(s);
        s = idle(); s.stall = 1'b1; s.exmem_we = 1'b1; s.exmem_rd = 3'd2;
        s.exmem_val = 16'h1111; s.memwb_we = 1'b1; s.memwb_rd = 3'd2; s.memwb_val = 16'h2222;
        step(s);
        s.exmem_we = 1'b0;
        step(s);
        s = idle(); s.id_valid = 1'b1;
        step(s);
        s = idle(); s.exmem_we = 1'b1; s.exmem_rd = 3'd0; s.exmem_val = 16'h1234;
        s.memwb_we = 1'b1; s.memwb_rd = 3'd0; s.memwb_val = 16'h5678;
        step(s);

        // Load-use: load to r3 followed by a reader of r3.
        s = idle(); s.id_valid = 1'b1; s.rd = 3'd3; s.mem_read = 1'b1; s.reg_write = 1'b1;
        step(s);
        s = idle(); s.id_valid = 1'b1; s.rs = 3'd3; s.rs_data = 16'h7777; s.rd = 3'd4;
        s.reg_write = 1'b1;
        step(s);
        step(s);
        step(idle());

        // Hold for three edges, then flush wins over stall.
        s = idle(); s.id_valid = 1'b1; s.rs = 3'd5; s.rs_data = 16'hA5A5; s.rt = 3'd6;
        s.rt_data = 16'h5A5A; s.op = 4'd3; s.rd = 3'd7; s.reg_write = 1'b1;
        step(s);
        for (int i = 0; i < 3; i++) begin
            s = rand_stim(); s.rst = 1'b0; s.flush = 1'b0; s.stall = 1'b1;
            step(s);
        end
        s = idle(); s.stall = 1'b1; s.flush = 1'b1;
        step(s);
        step(idle());

        // Immediate operand with forwarded store data.
        s = idle(); s.id_valid = 1'b1; s.alu_src = 1'b1; s.imm = 16'hFFF0; s.rt = 3'd4;
        s.rt_data = 16'h1234; s.mem_write = 1'b1;
        step(s);
        s = idle(); s.memwb_we = 1'b1; s.memwb_rd = 3'd4; s.memwb_val = 16'hBEEF;
        step(s);

        // Reset mid-stall.
        s = idle(); s.id_valid = 1'b1; s.rs = 3'd1; s.rs_data = 16'h4321; s.op = 4'd9;
        step(s);
        s = idle(); s.stall = 1'b1; s.rst = 1'b1;
        step(s);
        step(idle());

        for (int i = 0; i < 600; i++) step(rand_stim());

        @(negedge clk);
        #5;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
